ayatsuki_bus_arbiter: RTL and testbench
=======================================

# ayatsuki_bus_arbiter

Shares the single SoC memory-bus slave port between up to `NUM_MASTERS` requesters (instruction fetch, load/store unit, debug/DMA) inside `ayatsuki_soc`. It accepts one transaction at a time, forwards it to the slave with a registered request, and routes the completion back to the owner. Exactly one transaction is outstanding on the slave side. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- `NUM_MASTERS`, 3, number of requesters, 2..8
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits

- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m_req`  in  NUM_MASTERS  per-master request; held until granted
- `m_we`  in  NUM_MASTERS  per-master write enable, 1 = write
- `m_addr`  in  NUM_MASTERS*ADDR_W  packed addresses, master i at bits [i*ADDR_W +: ADDR_W]
- `m_wdata`  in  NUM_MASTERS*DATA_W  packed write data
- `m_be`  in  NUM_MASTERS*DATA_W/8  packed byte enables
- `m_gnt`  out  NUM_MASTERS  one-hot, one-cycle accept pulse
- `m_rvalid`  out  NUM_MASTERS  one-hot, one-cycle completion pulse
- `m_rdata`  out  DATA_W  read data, broadcast to all masters
- `s_req`  out  1  slave request
- `s_we`, `s_addr`, `s_wdata`, `s_be`  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction
- `s_gnt`  in  1  slave accepts `s_req` this cycle
- `s_rvalid`  in  1  slave completion, for both reads and writes
- `s_rdata`  in  DATA_W  slave read data, valid with `s_rvalid`

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- IDLE:
  - If any `m_req` is set, the combinational winner gets `m_gnt[w]=1` in this cycle.
  - On the edge, latch the winner's we/addr/wdata/be and owner index `w`, then go to ISSUE.
  - With no request, stay in IDLE with `m_gnt=0`.
- ISSUE:
  - `s_req=1`, driving the latched fields.
  - On `s_gnt=1` with `s_rvalid=0`, go to WAIT.
  - On `s_gnt=1` with `s_rvalid=1`, complete and go to IDLE.
  - With `s_gnt=0`, hold; fields remain stable.
- WAIT:
  - `s_req=0`.
  - On `s_rvalid`, complete and go to IDLE.
- Completion:
  - `m_rvalid[owner]` equals `s_rvalid`, combinationally, only in the completing state.
  - `m_rdata` is `s_rdata` passed through.
  - In IDLE, `s_rvalid` is ignored and `m_rvalid=0`.
- Masters must keep `m_req` and its fields stable until `m_gnt`. A master may re-request in the cycle after `m_gnt`, but is only considered in IDLE.
- `m_gnt` is never asserted outside IDLE. At most one bit of `m_gnt` and at most one bit of `m_rvalid` is set at any time.
- Round-robin pointer `last` (log2 NUM_MASTERS bits) updates to `w` on every grant. Reset value is `NUM_MASTERS-1`, so master 0 wins first.

## Timing
- Reset values: `s_req=0`, `s_we=0`, `s_addr=0`, `s_wdata=0`, `s_be=0`, `m_gnt=0`, `m_rvalid=0`, state IDLE, `last=NUM_MASTERS-1`.
- Grant is seen in the same cycle as the request (cycle 0). `s_req` rises in cycle 1.
- Minimum turnaround, with a zero-wait slave that returns `s_rvalid` one cycle after `s_gnt`:
  - cycle 0: grant
  - cycle 1: `s_gnt`
  - cycle 2: `m_rvalid`
  - cycle 3: IDLE, so the next grant is possible in cycle 3
- Back-to-back throughput is 1 transaction per 3 cycles minimum. With same-cycle `s_gnt`+`s_rvalid`, it is 1 per 2 cycles.
- Reset asserted mid-transaction: all outputs go immediately to their reset values and the transaction is dropped. A stale `s_rvalid` after release is ignored because the state is IDLE.
- A request that rises while the block is in ISSUE/WAIT waits; it is arbitrated on the first IDLE cycle.

## Configuration
- `AYATSUKI_ARB_ROUND_ROBIN_EN`
  - Defined: winner is the first set `m_req` searching upward from `last+1`, wrapping modulo `NUM_MASTERS`.
  - Undefined: fixed priority, lowest index wins. `last` is still maintained but unused.

## Test plan
- Single read: master 1 requests addr 0x0000_0100 and the slave returns 0xDEAD_BEEF one cycle after `s_gnt`. Expect `m_gnt=3'b010` at cycle 0, `s_req` at cycle 1, `m_rvalid=3'b010` with `m_rdata=0xDEAD_BEEF` at cycle 2.
- Slave stall: `s_gnt` is held low for 4 cycles. Expect `s_req` and `s_addr`/`s_wdata`/`s_be` constant for all 4 cycles, and no `m_gnt` while master 0 is also requesting.
- Contention, all 3 masters requesting continuously:
  - With RR_EN: grant order 0,1,2,0.
  - Without it: 0,0,0,0.
- Write with be=4'b0011 and wdata 0x1234_5678 from master 2. Expect `s_we=1` with the same be/wdata on the slave side, and `m_rvalid=3'b100` on completion.
- Same-cycle `s_gnt`+`s_rvalid` in ISSUE. Expect `m_rvalid` in that cycle, IDLE next, and a new grant in that next cycle.
- Reset pulse while in WAIT, followed by `s_rvalid` 2 cycles after release. Expect `s_req=0` and `m_rvalid=0` throughout, and master 0 wins the next grant.

Source files
------------

// File: rtl/ayatsuki_bus_arbiter.sv
// ayatsuki_bus_arbiter: shares one memory-bus slave port between NUM_MASTERS requesters.
// Define AYATSUKI_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module ayatsuki_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_req,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_be,
  input  logic                            s_gnt,
  input  logic                            s_rvalid,
  input  logic [DATA_W-1:0]               s_rdata
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   win, idx;
  logic              win_valid;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]    be_q, be_d;
  logic              complete;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];
  logic [BeW-1:0]    be_arr    [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = m_wdata[g*DATA_W +: DATA_W];
    assign be_arr[g]    = m_be[g*BeW +: BeW];
  end

  always_comb begin : arbitrate
    win       = '0;
    win_valid = 1'b0;
    idx       = '0;
`ifdef AYATSUKI_ARB_ROUND_ROBIN_EN
    // Search upward from the master after the last winner, wrapping around.
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = IdxW'((32'(last_q) + k) % NUM_MASTERS);
      if (!win_valid && m_req[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
`else
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = IdxW'(i);
      if (!win_valid && m_req[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
`endif
  end

  always_comb begin : fsm
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    m_gnt    = '0;
    m_rvalid = '0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gate the combinational grant so it stays low while reset is held.
        if (win_valid && !rst) begin
          m_gnt[win] = 1'b1;
          owner_d    = win;
          last_d     = win;
          we_d       = m_we[win];
          addr_d     = addr_arr[win];
          wdata_d    = wdata_arr[win];
          be_d       = be_arr[win];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (s_gnt) begin
          if (s_rvalid) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (s_rvalid) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (complete) begin
      m_rvalid[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign s_req   = (state_q == StIssue);
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_be    = be_q;
  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_ayatsuki_bus_arbiter.sv
// Self-checking bench for ayatsuki_bus_arbiter: vector table, corner sequences, random vs model.
// Follows AYATSUKI_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_ayatsuki_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_we, m_gnt, m_rvalid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*BW-1:0] m_be;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [BW-1:0]   s_be;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] fa [N];
  logic [DW-1:0] fd [N];
  logic [BW-1:0] fb [N];
  logic          fw [N];

  always #5 clk = ~clk;

  ayatsuki_bus_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_be    (s_be),
    .s_gnt   (s_gnt),
    .s_rvalid(s_rvalid),
    .s_rdata (s_rdata)
  );

  typedef struct packed {
    logic [N-1:0] req;
    logic         sg;
    logic         sr;
    logic [N-1:0] gnt;
    logic         sreq;
    logic [N-1:0] rv;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_fields();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = fa[i];
      m_wdata[i*DW +: DW] = fd[i];
      m_be[i*BW +: BW]    = fb[i];
      m_we[i]             = fw[i];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = 32'hDEAD_BEEF;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_fields(input string tag, input int o);
    check({tag, "_s_addr"},  64'(s_addr),  64'(fa[o]));
    check({tag, "_s_wdata"}, 64'(s_wdata), 64'(fd[o]));
    check({tag, "_s_be"},    64'(s_be),    64'(fb[o]));
    check({tag, "_s_we"},    64'(s_we),    64'(fw[o]));
  endtask

  // Reference arbitration: fixed or rotating search over the request vector.
  function automatic int pick(input logic [N-1:0] req, input int last);
`ifdef AYATSUKI_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
`else
    for (int i = 0; i < N; i++) if (req[i]) return i;
`endif
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int owner;
    int order [4];
    int exp_order [4];
    int got;
    int w;
    int drop;
    logic busy, sent;
    int mown, mlast;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    logic [BW-1:0] tb;
    logic tw;
    logic [N-1:0] eg, er;
    logic es;

    for (int i = 0; i < N; i++) begin
      fa[i] = 32'(i) * 32'h100;
      fd[i] = (i == 2) ? 32'h1234_5678 : 32'h1111_1111 * 32'(i + 1);
      fb[i] = (i == 2) ? 4'b0011 : 4'hF;
      fw[i] = (i == 2);
    end
    pack_fields();

    // Reset values, with requests pending to show the grant is suppressed.
    rst = 1'b1; m_req = 3'b111; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #4;
    check("rst_s_req",    64'(s_req),    64'(0));
    check("rst_s_we",     64'(s_we),     64'(0));
    check("rst_s_addr",   64'(s_addr),   64'(0));
    check("rst_s_wdata",  64'(s_wdata),  64'(0));
    check("rst_s_be",     64'(s_be),     64'(0));
    check("rst_m_gnt",    64'(m_gnt),    64'(0));
    check("rst_m_rvalid", 64'(m_rvalid), 64'(0));
    do_reset();

    // Single read, same-cycle completion, write with a 4-cycle slave stall.
    vt[0]  = '{req: 3'b010, sg: 1'b0, sr: 1'b0, gnt: 3'b010, sreq: 1'b0, rv: 3'b000};
    vt[1]  = '{req: 3'b000, sg: 1'b1, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[2]  = '{req: 3'b000, sg: 1'b0, sr: 1'b1, gnt: 3'b000, sreq: 1'b0, rv: 3'b010};
    vt[3]  = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b001, sreq: 1'b0, rv: 3'b000};
    vt[4]  = '{req: 3'b000, sg: 1'b1, sr: 1'b1, gnt: 3'b000, sreq: 1'b1, rv: 3'b001};
    vt[5]  = '{req: 3'b100, sg: 1'b0, sr: 1'b0, gnt: 3'b100, sreq: 1'b0, rv: 3'b000};
    vt[6]  = '{req: 3'b000, sg: 1'b0, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[7]  = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[8]  = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[9]  = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[10] = '{req: 3'b001, sg: 1'b1, sr: 1'b0, gnt: 3'b000, sreq: 1'b1, rv: 3'b000};
    vt[11] = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b000, sreq: 1'b0, rv: 3'b000};
    vt[12] = '{req: 3'b001, sg: 1'b0, sr: 1'b1, gnt: 3'b000, sreq: 1'b0, rv: 3'b100};
    vt[13] = '{req: 3'b001, sg: 1'b0, sr: 1'b0, gnt: 3'b001, sreq: 1'b0, rv: 3'b000};
    owner = 0;
    for (int i = 0; i < 14; i++) begin
      m_req = vt[i].req; s_gnt = vt[i].sg; s_rvalid = vt[i].sr;
      #4;
      check("tbl_m_gnt",    64'(m_gnt),    64'(vt[i].gnt));
      check("tbl_s_req",    64'(s_req),    64'(vt[i].sreq));
      check("tbl_m_rvalid", 64'(m_rvalid), 64'(vt[i].rv));
      if (vt[i].rv != '0) check("tbl_m_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
      if (vt[i].sreq) check_fields("tbl", owner);
      for (int j = 0; j < N; j++) if (vt[i].gnt[j]) owner = j;
      next_cycle();
    end

    // Contention: all masters requesting, slave completes in the issue cycle.
    do_reset();
`ifdef AYATSUKI_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    m_req = 3'b111; s_gnt = 1'b1; s_rvalid = 1'b1;
    got = 0;
    for (int c = 0; c < 16 && got < 4; c++) begin
      #4;
      for (int j = 0; j < N; j++) if (m_gnt[j]) begin order[got] = j; got++; end
      next_cycle();
    end
    check("cont_grant_count", 64'(got), 64'(4));
    for (int t = 0; t < got; t++) check("cont_order", 64'(order[t]), 64'(exp_order[t]));

    // Reset pulse while waiting for completion; stale completion must be ignored.
    do_reset();
    m_req = 3'b010;
    #4; check("rw_gnt", 64'(m_gnt), 64'(3'b010));
    next_cycle();
    m_req = 3'b000; s_gnt = 1'b1;
    #4; check("rw_issue_s_req", 64'(s_req), 64'(1));
    next_cycle();
    s_gnt = 1'b0;
    #4; check("rw_wait_s_req", 64'(s_req), 64'(0));
    next_cycle();
    rst = 1'b1; s_rvalid = 1'b1;
    #4;
    check("rw_rst_s_req",    64'(s_req),    64'(0));
    check("rw_rst_m_rvalid", 64'(m_rvalid), 64'(0));
    next_cycle();
    rst = 1'b0; s_rvalid = 1'b0;
    next_cycle();
    s_rvalid = 1'b1;
    #4;
    check("rw_stale_m_rvalid", 64'(m_rvalid), 64'(0));
    check("rw_stale_s_req",    64'(s_req),    64'(0));
    next_cycle();
    s_rvalid = 1'b0; m_req = 3'b111;
    #4; check("rw_next_gnt", 64'(m_gnt), 64'(3'b001));
    next_cycle();

    // Randomized traffic against a transaction-level model.
    do_reset();
    busy = 1'b0; sent = 1'b0; mown = 0; mlast = N - 1; drop = -1;
    ta = '0; td = '0; tb = '0; tw = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (drop >= 0) m_req[drop] = 1'b0;
      drop = -1;
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(1, 0) == 1) begin
          m_req[i] = 1'b1;
          fa[i] = $urandom; fd[i] = $urandom; fb[i] = 4'($urandom); fw[i] = 1'($urandom);
        end
      end
      pack_fields();
      s_gnt = 1'($urandom); s_rvalid = 1'($urandom); s_rdata = $urandom;
      eg = '0; er = '0; es = 1'b0; w = -1;
      if (!busy) begin
        w = pick(m_req, mlast);
        if (w >= 0) eg[w] = 1'b1;
      end else if (!sent) begin
        es = 1'b1;
        if (s_gnt && s_rvalid) er[mown] = 1'b1;
      end else if (s_rvalid) begin
        er[mown] = 1'b1;
      end
      #4;
      check("rnd_m_gnt",    64'(m_gnt),    64'(eg));
      check("rnd_m_rvalid", 64'(m_rvalid), 64'(er));
      check("rnd_s_req",    64'(s_req),    64'(es));
      check("rnd_m_rdata",  64'(m_rdata),  64'(s_rdata));
      if (es) begin
        check("rnd_s_addr",  64'(s_addr),  64'(ta));
        check("rnd_s_wdata", 64'(s_wdata), 64'(td));
        check("rnd_s_be",    64'(s_be),    64'(tb));
        check("rnd_s_we",    64'(s_we),    64'(tw));
      end
      if (!busy) begin
        if (w >= 0) begin
          busy = 1'b1; sent = 1'b0; mown = w; mlast = w; drop = w;
          ta = fa[w]; td = fd[w]; tb = fb[w]; tw = fw[w];
        end
      end else if (!sent) begin
        if (s_gnt) begin
          if (s_rvalid) busy = 1'b0;
          else sent = 1'b1;
        end
      end else if (s_rvalid) begin
        busy = 1'b0;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
